mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage bus controller placed directly downstream of the MMU. It takes the translated physical address and the MMU fault flag for each load/store, and either raises an exception or runs one transaction on the external memory bus using a req/ack handshake. While the bus is busy it stalls the pipeline. It returns lane-aligned, sign- or zero-extended load data to the pipeline.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of WAIT cycles before the controller aborts with a bus timeout; 8-bit counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- clr  in  1  reset, asynchronous, active-low
- req  in  1  load/store request from the MEM stage; held high until the stage advances
- we  in  1  1 = store, 0 = load
- size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word
- lsigned  in  1  sign-extend load data when 1
- paddr  in  32  physical address from the MMU
- mmu_error  in  1  MMU page-mismatch flag
- mmu_en  in  1  user mode; mmu_error is honoured only when this is 1
- wdata  in  32  store data, right-aligned
- rdata  out  32  extended load data; valid in the DONE cycle
- stall  out  1  pipeline hold request
- exc  out  1  one-cycle exception pulse
- exc_code  out  2  01 = MMU fault, 10 = misaligned, 11 = bus timeout; 00 when exc = 0
- bus_req  out  1  bus request, registered
- bus_we  out  1  bus write, registered
- bus_addr  out  32  registered; {paddr[31:2], 2'b00}
- bus_be  out  4  byte enables, little-endian; lane 0 = bits [7:0]
- bus_wdata  out  32  store data replicated or shifted onto the active lanes
- bus_ack  in  1  slave completion; bus_rdata is valid in the same cycle
- bus_rdata  in  32  read data

## Operation
States:
- IDLE: waiting for a request.
- WAIT: bus transaction in progress.
- DONE: one-cycle completion or exception slot.

Fault and alignment checks:
- The check is combinational in IDLE when req = 1.
- MMU fault: mmu_en & mmu_error.
- Misaligned: a half access with paddr[0] = 1, or a word access with paddr[1:0] ≠ 0.
- Priority: MMU fault over misaligned.

IDLE & req & fault:
- exc = 1 with the matching code, stall = 0, in the same cycle.
- No bus activity. Stay in IDLE.

IDLE & req & no fault:
- stall = 1.
- Register the bus outputs: bus_req = 1, bus_addr, bus_be, bus_wdata, bus_we.
- Clear the timeout counter. Next state is WAIT.

Byte enables:
- byte: 0001 << paddr[1:0]
- half: 0011 << paddr[1:0]
- word: 1111
- bus_wdata = wdata shifted left by 8 × paddr[1:0].

WAIT:
- stall = 1 and bus outputs are held stable.
- On bus_ack: deassert bus_req at the next edge, capture the extracted and extended load data into rdata, and go to DONE.
- Otherwise increment the counter. When the counter reaches TIMEOUT, deassert bus_req, set a pending timeout flag, and go to DONE.

DONE:
- stall = 0.
- If the timeout flag is set: exc = 1, exc_code = 11.
- The next state is always IDLE. req is ignored in DONE because it is still the same instruction.

Load data extraction:
- Shift bus_rdata right by 8 × paddr[1:0] (address registered at request).
- Keep 8 or 16 bits according to size.
- Extend using lsigned.
- For a store, rdata is left unchanged.

## Timing
Reset (clr = 0):
- state = IDLE; counter = 0; timeout flag cleared.
- bus_req = 0, bus_we = 0, bus_be = 0, bus_addr = 0, bus_wdata = 0, rdata = 0.
- stall = 0, exc = 0, exc_code = 0.
- Reset mid-transaction drops bus_req at once (asynchronously). The slave must tolerate an abandoned cycle.

Latency:
- An ack arriving k cycles after bus_req first rises gives a total stall of k + 1 cycles.
- The request cycle plus k WAIT cycles are stalled; DONE follows with stall = 0.
- A zero-wait slave (ack in the first WAIT cycle) gives 2 stall cycles.
- Minimum request-to-request spacing is 3 cycles: IDLE, WAIT, DONE.

Boundary conditions:
- bus_ack outside WAIT is ignored.
- bus_ack in the same cycle the counter reaches TIMEOUT counts as success; no exception is raised.
- A fault exception produces no stall cycle.

## Test plan
- Word load at paddr 0x0000_1004, ack after 2 WAIT cycles, bus_rdata 0xDEADBEEF -> bus_be = 1111, bus_addr = 0x1004, stall high for 3 cycles, rdata = 0xDEADBEEF in DONE.
- Signed byte load at 0x...03 with bus_rdata 0x80xxxxxx -> bus_be = 1000, rdata = 0xFFFFFF80. Repeat with lsigned = 0 -> 0x00000080.
- Half store of 0x1234 at 0x...02 -> bus_be = 1100, bus_wdata[31:16] = 0x1234, bus_we = 1.
- mmu_en = 1 with mmu_error = 1 and misaligned word at 0x...01 -> exc pulse with code 01, stall = 0, bus_req never rises. Repeat with mmu_en = 0 -> code 10.
- Slave never acks, TIMEOUT = 4 -> bus_req high for 4 WAIT cycles, then exc code 11 in DONE, then back to IDLE.
- Assert clr low during WAIT -> bus_req, stall and exc go to 0 immediately. After release, the next request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage bus controller sitting directly after the MMU. For each
// load/store it either raises an exception (MMU fault or misalignment) or runs
// one req/ack transaction on the external memory bus, stalling the pipeline
// while the bus is busy. Load data is returned lane-aligned and sign- or
// zero-extended.
//
// Parameters:
//   TIMEOUT    maximum number of WAIT cycles before aborting with a bus timeout
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   clr        asynchronous active-low reset
//   req        load/store request from the MEM stage (held until stage advances)
//   we         1 = store, 0 = load
//   size       00 byte, 01 half, 10/11 word
//   lsigned    sign-extend load data when 1
//   paddr      physical address from the MMU
//   mmu_error  MMU page-mismatch flag
//   mmu_en     user mode; mmu_error is only honoured when set
//   wdata      right-aligned store data
//   rdata      extended load data, valid in the DONE cycle (registered)
//   stall      pipeline hold request
//   exc        one-cycle exception pulse
//   exc_code   01 MMU fault, 10 misaligned, 11 bus timeout, 00 when exc = 0
//   bus_req    bus request (registered)
//   bus_we     bus write (registered)
//   bus_addr   word-aligned bus address (registered)
//   bus_be     little-endian byte enables (registered)
//   bus_wdata  store data shifted onto the active lanes (registered)
//   bus_ack    slave completion; bus_rdata valid in the same cycle
//   bus_rdata  bus read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        lsigned,
  input  logic [31:0] paddr,
  input  logic        mmu_error,
  input  logic        mmu_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        exc,
  output logic [1:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_MMU     = 2'b01;
  localparam logic [1:0] CODE_ALIGN   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  // Select the addressed lane(s) of a right-shifted word and extend them.
  function automatic logic [31:0] extend_load(input logic [31:0] sh,
                                              input logic [1:0]  sz,
                                              input logic        sg);
    logic [31:0] res;
    case (sz)
      2'b00:   res = {{24{sg & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{sg & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // State and per-transaction context
  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic        tmo_r;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic        sign_r;
  logic        we_r;

  // Combinational decode
  logic        mmu_fault_s;
  logic        misalign_s;
  logic        start_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_sh_s;
  logic [8:0]  cnt_next_s;
  logic        ack_s;
  logic        tmo_hit_s;
  logic [31:0] rd_shift_s;
  logic [31:0] rd_ext_s;
  logic        stall_s;
  logic        exc_s;
  logic [1:0]  exc_code_s;

  // Fault and alignment checks against the live request.
  always_comb begin
    mmu_fault_s = mmu_en & mmu_error;
    misalign_s  = 1'b0;
    case (size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = paddr[0];
      default: misalign_s = (paddr[1:0] != 2'b00);
    endcase
    start_s = (state_r == ST_IDLE) & req & ~mmu_fault_s & ~misalign_s;
  end

  // Byte enables and lane-shifted store data for the request being launched.
  always_comb begin
    be_s = 4'b0000;
    case (size)
      2'b00:   be_s = 4'b0001 << paddr[1:0];
      2'b01:   be_s = 4'b0011 << paddr[1:0];
      default: be_s = 4'b1111;
    endcase
    wdata_sh_s = wdata << {paddr[1:0], 3'b000};
  end

  // Bus completion / timeout decisions while a transaction is in flight.
  // An ack in the cycle the counter would reach TIMEOUT wins over the timeout.
  always_comb begin
    cnt_next_s = {1'b0, cnt_r} + 9'd1;
    ack_s      = (state_r == ST_WAIT) & bus_ack;
    if (state_r == ST_WAIT) begin
      tmo_hit_s = ~bus_ack & (cnt_next_s >= {1'b0, TIMEOUT});
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Load data extraction uses the offset and size captured at request time.
  always_comb begin
    rd_shift_s = bus_rdata >> {off_r, 3'b000};
    rd_ext_s   = extend_load(rd_shift_s, size_r, sign_r);
  end

  // Pipeline-facing handshake; forced low while reset is asserted so that a
  // reset mid-transaction releases the pipeline immediately.
  always_comb begin
    stall_s    = 1'b0;
    exc_s      = 1'b0;
    exc_code_s = CODE_NONE;
    if (!clr) begin
      stall_s    = 1'b0;
      exc_s      = 1'b0;
      exc_code_s = CODE_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            if (mmu_fault_s) begin
              exc_s      = 1'b1;
              exc_code_s = CODE_MMU;
            end else if (misalign_s) begin
              exc_s      = 1'b1;
              exc_code_s = CODE_ALIGN;
            end else begin
              stall_s = 1'b1;
            end
          end else begin
            stall_s = 1'b0;
          end
        end
        ST_WAIT: begin
          stall_s = 1'b1;
        end
        ST_DONE: begin
          if (tmo_r) begin
            exc_s      = 1'b1;
            exc_code_s = CODE_TIMEOUT;
          end else begin
            exc_s = 1'b0;
          end
        end
        default: begin
          stall_s = 1'b0;
        end
      endcase
    end
  end

  assign stall    = stall_s;
  assign exc      = exc_s;
  assign exc_code = exc_code_s;

  // Controller state, timeout counter and pending-timeout flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      tmo_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            cnt_r   <= 8'd0;
            tmo_r   <= 1'b0;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (ack_s) begin
            state_r <= ST_DONE;
          end else if (tmo_hit_s) begin
            cnt_r   <= cnt_next_s[7:0];
            tmo_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_next_s[7:0];
          end
        end
        ST_DONE: begin
          // req is still the same instruction here, so it is not sampled.
          tmo_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          tmo_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered bus outputs plus the context needed to decode the read data.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
      off_r     <= 2'b00;
      size_r    <= 2'b00;
      sign_r    <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            bus_req   <= 1'b1;
            bus_we    <= we;
            bus_addr  <= {paddr[31:2], 2'b00};
            bus_be    <= be_s;
            bus_wdata <= wdata_sh_s;
            off_r     <= paddr[1:0];
            size_r    <= size;
            sign_r    <= lsigned;
            we_r      <= we;
          end else begin
            bus_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (ack_s || tmo_hit_s) begin
            bus_req <= 1'b0;
          end else begin
            bus_req <= 1'b1;
          end
        end
        ST_DONE: begin
          bus_req <= 1'b0;
        end
        default: begin
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Load result register; stores and timeouts leave it untouched.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rdata <= 32'h0000_0000;
    end else begin
      if (ack_s && !we_r) begin
        rdata <= rd_ext_s;
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule
